// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sequencer and its MISR.
package truth_table_pkg;

  localparam int unsigned ROW_W    = 4;
  localparam int unsigned NUM_ROWS = 16;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned ERR_W    = 5;
  localparam int unsigned MISR_W   = 16;

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // One MISR step: shift left, fold the polynomial on carry-out, then mix in data.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                  input logic [MISR_W-1:0] d);
    return {s[MISR_W-2:0], 1'b0} ^ (s[MISR_W-1] ? MISR_POLY : '0) ^ d;
  endfunction

endpackage

// File: rtl/tt_misr.sv
// 16-bit multiple-input signature register; seeded on sweep start, stepped per capture.
module tt_misr
  import truth_table_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_ld,
  input  logic              shift_en,
  input  logic [MISR_W-1:0] din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (seed_ld) begin
      sig_d = MISR_SEED;
    end else if (shift_en) begin
      sig_d = misr_step(sig_q, din);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks a 4-input function block through all 16 rows, compares against a golden ROM,
// and streams captures. Define TT_SEQ_MISR_EN to add a signature over captured rows.
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned FUNC_W        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ROW_W-1:0]  row_sel,
  input  logic [FUNC_W-1:0] f_in,
  output logic [ROW_W-1:0]  exp_addr,
  input  logic [FUNC_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ROW_W-1:0]  first_err_row,
  output logic [FUNC_W-1:0] first_err_mask,
  output logic              cap_valid,
  output logic [ROW_W-1:0]  cap_row,
  output logic [FUNC_W-1:0] cap_data,
  output logic [MISR_W-1:0] sig
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ROW_W-1:0]  first_row_q, first_row_d;
  logic [FUNC_W-1:0] first_mask_q, first_mask_d;
  logic              cap_valid_q, cap_valid_d;
  logic [ROW_W-1:0]  cap_row_q, cap_row_d;
  logic [FUNC_W-1:0] cap_data_q, cap_data_d;
  logic              seed_ld_c;
  logic              shift_en_c;
  logic              mismatch_c;

  assign mismatch_c = (f_in != exp_data);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    first_row_d  = first_row_q;
    first_mask_d = first_mask_q;
    cap_valid_d  = 1'b0;
    cap_row_d    = cap_row_q;
    cap_data_d   = cap_data_q;
    seed_ld_c    = 1'b0;
    shift_en_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        row_d = '0;
        if (start && !abort) begin
          err_d        = '0;
          first_row_d  = '0;
          first_mask_d = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          cnt_d        = CNT_RELOAD;
          seed_ld_c    = 1'b1;
          state_d      = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          row_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          row_d   = '0;
          cnt_d   = '0;
        end else begin
          cap_valid_d = 1'b1;
          cap_row_d   = row_q;
          cap_data_d  = f_in;
          shift_en_c  = 1'b1;
          if (mismatch_c) begin
            err_d = err_q + ERR_W'(1);
            if (err_q == '0) begin
              first_row_d  = row_q;
              first_mask_d = f_in ^ exp_data;
            end
          end
          // Last row finishes the sweep instead of wrapping back to row 0.
          if (row_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            cnt_d   = CNT_RELOAD;
            state_d = SETTLE;
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        row_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      first_row_q  <= '0;
      first_mask_q <= '0;
      cap_valid_q  <= 1'b0;
      cap_row_q    <= '0;
      cap_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      first_row_q  <= first_row_d;
      first_mask_q <= first_mask_d;
      cap_valid_q  <= cap_valid_d;
      cap_row_q    <= cap_row_d;
      cap_data_q   <= cap_data_d;
    end
  end

  assign row_sel        = row_q;
  assign exp_addr       = row_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_row  = first_row_q;
  assign first_err_mask = first_mask_q;
  assign cap_valid      = cap_valid_q;
  assign cap_row        = cap_row_q;
  assign cap_data       = cap_data_q;

`ifdef TT_SEQ_MISR_EN
  tt_misr u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed_ld  (seed_ld_c),
    .shift_en (shift_en_c),
    .din      (MISR_W'(f_in)),
    .sig      (sig)
  );
`else
  logic unused_misr_ctrl;
  assign unused_misr_ctrl = seed_ld_c ^ shift_en_c;
  assign sig              = '0;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: clean/corrupt sweeps, abort, mid-sweep reset, settle=3.
module tb_truth_table_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [3:0]  row_sel, exp_addr, first_err_row, cap_row;
  logic [9:0]  f_in, exp_data, first_err_mask, cap_data;
  logic        busy, done, pass, cap_valid;
  logic [4:0]  err_count;
  logic [15:0] sig;

  logic        start3, abort3;
  logic [3:0]  row_sel3, exp_addr3, first_err_row3, cap_row3;
  logic [9:0]  f_in3, exp_data3, first_err_mask3, cap_data3;
  logic        busy3, done3, pass3, cap_valid3;
  logic [4:0]  err_count3;
  logic [15:0] sig3;

  logic [9:0]  rom [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Reference function block: {w^z, x&y, wxyz, ~wxyz}.
  function automatic logic [9:0] func(input logic [3:0] r);
    return {r[3] ^ r[0], r[2] & r[1], r, ~r};
  endfunction

  function automatic logic [15:0] misr_model();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int r = 0; r < 16; r++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {6'b0, func(4'(r))};
    end
    return s;
  endfunction

  assign f_in      = func(row_sel);
  assign exp_data  = rom[exp_addr];
  assign f_in3     = func(row_sel3);
  assign exp_data3 = rom[exp_addr3];

  truth_table_sequencer #(.SETTLE_CYCLES(1), .FUNC_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .row_sel(row_sel), .f_in(f_in), .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_row(first_err_row), .first_err_mask(first_err_mask),
    .cap_valid(cap_valid), .cap_row(cap_row), .cap_data(cap_data), .sig(sig)
  );

  truth_table_sequencer #(.SETTLE_CYCLES(3), .FUNC_W(10)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .row_sel(row_sel3), .f_in(f_in3), .exp_addr(exp_addr3), .exp_data(exp_data3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
    .first_err_row(first_err_row3), .first_err_mask(first_err_mask3),
    .cap_valid(cap_valid3), .cap_row(cap_row3), .cap_data(cap_data3), .sig(sig3)
  );

  // Stimulus only: pulse start, then count cycles to done and tally capture order errors.
  task automatic run_sweep(output int lat, output int ncap, output int nbad);
    bit got;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 0; ncap = 0; nbad = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (cap_valid) begin
        if (cap_row !== 4'(ncap) || cap_data !== func(4'(ncap))) nbad++;
        ncap++;
      end
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    #12;
    checks++;
    if ({busy, done, pass, cap_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, cap_valid});
    end
    checks++;
    if ({row_sel, err_count, first_err_row, cap_row} !== 17'h0) begin
      errors++; $display("FAIL reset_vals: got %h expected 0", {row_sel, err_count, first_err_row, cap_row});
    end
    checks++;
    if ({first_err_mask, cap_data, sig} !== 36'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {first_err_mask, cap_data, sig});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_sweep();
    int lat, ncap, nbad;
    logic [15:0] exp_sig;
`ifdef TT_SEQ_MISR_EN
    exp_sig = misr_model();
`else
    exp_sig = 16'h0000;
`endif
    run_sweep(lat, ncap, nbad);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL clean_latency: got %0d expected 33", lat); end
    checks++;
    if (ncap != 16 || nbad != 0) begin
      errors++; $display("FAIL clean_caps: got count %0d bad %0d expected 16/0", ncap, nbad);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 5'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL clean_status: got pass %b err %0d busy %b expected 1/0/0", pass, err_count, busy);
    end
    checks++;
    if (sig !== exp_sig) begin errors++; $display("FAIL clean_sig: got %h expected %h", sig, exp_sig); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pass !== 1'b1 || row_sel !== 4'd0) begin
      errors++; $display("FAIL done_pulse: got done %b pass %b row %0d expected 0/1/0", done, pass, row_sel);
    end
  endtask

  task automatic test_single_err();
    int lat, ncap, nbad;
    rom[5] = rom[5] ^ 10'b0000001000;
    run_sweep(lat, ncap, nbad);
    checks++;
    if (lat != 33 || err_count !== 5'd1 || pass !== 1'b0) begin
      errors++; $display("FAIL err1_status: got lat %0d err %0d pass %b expected 33/1/0", lat, err_count, pass);
    end
    checks++;
    if (first_err_row !== 4'd5 || first_err_mask !== 10'b0000001000) begin
      errors++; $display("FAIL err1_first: got row %0d mask %b expected 5/0000001000", first_err_row, first_err_mask);
    end
    rom[5] = func(4'd5);
  endtask

  task automatic test_two_err();
    int lat, ncap, nbad;
    rom[2] = rom[2] ^ 10'h003;
    rom[9] = rom[9] ^ 10'h200;
    run_sweep(lat, ncap, nbad);
    checks++;
    if (err_count !== 5'd2 || pass !== 1'b0) begin
      errors++; $display("FAIL err2_status: got err %0d pass %b expected 2/0", err_count, pass);
    end
    checks++;
    if (first_err_row !== 4'd2 || first_err_mask !== 10'h003) begin
      errors++; $display("FAIL err2_first: got row %0d mask %h expected 2/003", first_err_row, first_err_mask);
    end
    rom[2] = func(4'd2);
    rom[9] = func(4'd9);
  endtask

  task automatic test_abort();
    int n, ncap, ndone, nlate;
    bit found;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0; ncap = 0; found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (cap_valid) begin
        if (cap_row !== 4'(ncap)) begin
          errors++; $display("FAIL abort_order: got row %0d expected %0d", cap_row, ncap);
        end
        ncap++;
      end
      start = (n == 3 || n == 8);
      if (row_sel == 4'd7) found = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!found || busy !== 1'b1) begin
      errors++; $display("FAIL abort_reach_row7: got found %0d busy %b expected 1/1", found, busy);
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cap_valid !== 1'b0 || row_sel !== 4'd0) begin
      errors++; $display("FAIL abort_idle: got busy %b cap %b row %0d expected 0/0/0", busy, cap_valid, row_sel);
    end
    ndone = 0; nlate = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
      if (cap_valid) nlate++;
    end
    checks++;
    if (ndone != 0 || nlate != 0 || ncap != 7 || pass !== 1'b0) begin
      errors++; $display("FAIL abort_after: got done %0d late %0d caps %0d pass %b expected 0/0/7/0", ndone, nlate, ncap, pass);
    end
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || row_sel !== 4'd0 || cap_valid !== 1'b0) begin
      errors++; $display("FAIL start_abort_idle: got busy %b row %0d cap %b expected 0/0/0", busy, row_sel, cap_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n, lat, ncap, nbad;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (row_sel != 4'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, cap_valid, row_sel, cap_row, cap_data} !== 22'h0) begin
      errors++; $display("FAIL reset_mid: got busy %b row %0d cap_row %0d cap_data %h expected all 0", busy, row_sel, cap_row, cap_data);
    end
    checks++;
    if (sig !== 16'h0000 || err_count !== 5'd0) begin
      errors++; $display("FAIL reset_mid_sig: got sig %h err %0d expected 0/0", sig, err_count);
    end
    @(negedge clk) rst_n = 1'b1;
    run_sweep(lat, ncap, nbad);
    checks++;
    if (lat != 33 || ncap != 16 || nbad != 0 || pass !== 1'b1) begin
      errors++; $display("FAIL post_reset_sweep: got lat %0d caps %0d bad %0d pass %b expected 33/16/0/1", lat, ncap, nbad, pass);
    end
  endtask

  task automatic test_settle3();
    int lat, ncap;
    bit got;
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    lat = 0; ncap = 0; got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (cap_valid3) ncap++;
      if (done3) got = 1'b1;
    end
    checks++;
    if (lat != 65) begin errors++; $display("FAIL settle3_latency: got %0d expected 65", lat); end
    checks++;
    if (ncap != 16 || pass3 !== 1'b1 || err_count3 !== 5'd0) begin
      errors++; $display("FAIL settle3_status: got caps %0d pass %b err %0d expected 16/1/0", ncap, pass3, err_count3);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = func(4'(i));
    test_reset();
    test_clean_sweep();
    test_single_err();
    test_two_err();
    test_abort();
    test_reset_mid();
    test_settle3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
